// File: rtl/button_press_classifier.sv
// button_press_classifier
// Classifies a debounced, active-high button level into press/release edges
// and gesture events: short press, long press with auto-repeat, and double click.
// Every output is a registered single-cycle pulse, except busy, which is a
// registered level that is high whenever the classifier is inside a gesture.
`timescale 1ns/1ps

module button_press_classifier #(
    parameter int unsigned LONG_CYC   = 25_000_000,
    parameter int unsigned DBL_CYC    = 12_500_000,
    parameter int unsigned REPEAT_CYC = 5_000_000,
    parameter int unsigned CNT_W      = 25
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_db,
    output logic press_pulse,
    output logic release_pulse,
    output logic short_press,
    output logic long_press,
    output logic repeat_pulse,
    output logic double_click,
    output logic busy
);

    typedef enum logic [2:0] {
        IDLE,
        PRESS1,
        WAIT2,
        PRESS2,
        HOLD
    } state_t;

    // Terminal timer values, truncated to the timer width.
    localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_CYC - 1);
    localparam logic [CNT_W-1:0] DBL_LAST    = CNT_W'(DBL_CYC - 1);
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYC - 1);

    state_t           state;
    state_t           next_state;
    logic [CNT_W-1:0] timer;
    logic [CNT_W-1:0] timer_nx;
    logic             btn_q;
    logic             rise;
    logic             fall;
    logic             short_nx;
    logic             long_nx;
    logic             repeat_nx;
    logic             double_nx;
    logic             repeat_wrap;

    assign rise = btn_db & ~btn_q;
    assign fall = ~btn_db & btn_q;

    // Gesture sequencing: release/press edges take priority over timer expiry.
    always_comb begin
        next_state  = state;
        short_nx    = 1'b0;
        long_nx     = 1'b0;
        repeat_nx   = 1'b0;
        double_nx   = 1'b0;
        repeat_wrap = 1'b0;
        case (state)
            IDLE: begin
                if (rise) begin
                    next_state = PRESS1;
                end
            end
            PRESS1: begin
                if (fall) begin
                    next_state = WAIT2;
                end else if (timer == LONG_LAST) begin
                    long_nx    = 1'b1;
                    next_state = HOLD;
                end
            end
            WAIT2: begin
                if (rise) begin
                    next_state = PRESS2;
                end else if (timer == DBL_LAST) begin
                    short_nx   = 1'b1;
                    next_state = IDLE;
                end
            end
            PRESS2: begin
                if (fall) begin
                    double_nx  = 1'b1;
                    next_state = IDLE;
                end
            end
            HOLD: begin
                if (fall) begin
                    next_state = IDLE;
                end else if (timer == REPEAT_LAST) begin
                    repeat_nx   = 1'b1;
                    repeat_wrap = 1'b1;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Timer restarts on every state change and on each repeat period; parked at 0 in IDLE.
    always_comb begin
        timer_nx = timer + 1'b1;
        if ((next_state != state) || repeat_wrap || (state == IDLE)) begin
            timer_nx = '0;
        end
    end

    // State, timer, edge history and registered output pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            timer         <= '0;
            btn_q         <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            short_press   <= 1'b0;
            long_press    <= 1'b0;
            repeat_pulse  <= 1'b0;
            double_click  <= 1'b0;
            busy          <= 1'b0;
        end else begin
            state         <= next_state;
            timer         <= timer_nx;
            btn_q         <= btn_db;
            press_pulse   <= rise;
            release_pulse <= fall;
            short_press   <= short_nx;
            long_press    <= long_nx;
            repeat_pulse  <= repeat_nx;
            double_click  <= double_nx;
            busy          <= (next_state != IDLE);
        end
    end

endmodule

// File: tb/tb_button_press_classifier.sv
// tb_button_press_classifier
// Directed gestures with hand-computed pulse cycles pushed to a scoreboard;
// a negedge monitor pops and compares every pulse the DUT produces.
`timescale 1ns/1ps

module tb_button_press_classifier;

    logic clk    = 1'b0;
    logic rst_n  = 1'b0;
    logic btn_db = 1'b0;
    logic press_pulse, release_pulse, short_press, long_press;
    logic repeat_pulse, double_click, busy;

    button_press_classifier #(
        .LONG_CYC  (8),
        .DBL_CYC   (4),
        .REPEAT_CYC(3),
        .CNT_W     (4)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .btn_db       (btn_db),
        .press_pulse  (press_pulse),
        .release_pulse(release_pulse),
        .short_press  (short_press),
        .long_press   (long_press),
        .repeat_pulse (repeat_pulse),
        .double_click (double_click),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    // Posedge counter: at the negedge after posedge k, cyc == k.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    localparam int EV_PRESS   = 0;
    localparam int EV_RELEASE = 1;
    localparam int EV_SHORT   = 2;
    localparam int EV_LONG    = 3;
    localparam int EV_REPEAT  = 4;
    localparam int EV_DOUBLE  = 5;

    typedef struct {
        int kind;
        int at;
    } ev_t;

    ev_t   exp_q[$];
    int    total = 0;
    int    bad   = 0;
    string names[6] = '{"press", "release", "short", "long", "repeat", "double"};

    // Monitor: every asserted pulse must match the next expected event in kind and cycle.
    always @(negedge clk) begin
        logic [5:0] obs;
        ev_t        e;
        obs = {double_click, repeat_pulse, long_press, short_press, release_pulse, press_pulse};
        if (rst_n) begin
            for (int k = 0; k < 6; k++) begin
                if (obs[k]) begin
                    total++;
                    if (exp_q.size() == 0) begin
                        bad++;
                        $display("FAIL unexpected_pulse: got %s@%0d, required no pulse", names[k], cyc);
                    end else begin
                        e = exp_q.pop_front();
                        if (e.kind != k || e.at != cyc) begin
                            bad++;
                            $display("FAIL event_match: got %s@%0d, required %s@%0d",
                                     names[k], cyc, names[e.kind], e.at);
                        end
                    end
                end
            end
            if (short_press || double_click) begin
                total++;
                if (busy !== 1'b0) begin
                    bad++;
                    $display("FAIL busy_on_idle_entry@%0d: got %b, required 0", cyc, busy);
                end
            end
            if (press_pulse) begin
                total++;
                if (busy !== 1'b1) begin
                    bad++;
                    $display("FAIL busy_on_press@%0d: got %b, required 1", cyc, busy);
                end
            end
        end
    end

    task automatic exp_ev(input int kind, input int at);
        ev_t e;
        e.kind = kind;
        e.at   = at;
        exp_q.push_back(e);
    endtask

    // Drive a level at the current negedge and keep it for n sampling posedges.
    task automatic hold(input logic v, input int n);
        btn_db = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic drain_check(input string name);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL %s_missing: got %0d expected events unseen, next %s@%0d, required 0",
                     name, exp_q.size(), names[exp_q[0].kind], exp_q[0].at);
            exp_q.delete();
        end
    endtask

    task automatic check_quiet(input string name);
        logic [6:0] v;
        v = {press_pulse, release_pulse, short_press, long_press, repeat_pulse, double_click, busy};
        total++;
        if (v !== 7'b0) begin
            bad++;
            $display("FAIL %s: got outputs %b, required 0000000", name, v);
        end
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int t;
        repeat (3) @(negedge clk);
        check_quiet("reset_state");
        rst_n = 1'b1;
        hold(1'b0, 3);

        // 1: short press
        t = cyc;
        exp_ev(EV_PRESS, t + 1);
        exp_ev(EV_RELEASE, t + 4);
        exp_ev(EV_SHORT, t + 8);
        hold(1'b1, 3);
        hold(1'b0, 10);
        drain_check("t1_short");

        // 2: long press with repeats, release produces nothing else
        t = cyc;
        exp_ev(EV_PRESS, t + 1);
        exp_ev(EV_LONG, t + 9);
        exp_ev(EV_REPEAT, t + 12);
        exp_ev(EV_REPEAT, t + 15);
        exp_ev(EV_REPEAT, t + 18);
        exp_ev(EV_RELEASE, t + 21);
        hold(1'b1, 20);
        hold(1'b0, 10);
        drain_check("t2_long");

        // 3: double click, no short press afterwards
        t = cyc;
        exp_ev(EV_PRESS, t + 1);
        exp_ev(EV_RELEASE, t + 3);
        exp_ev(EV_PRESS, t + 5);
        exp_ev(EV_RELEASE, t + 7);
        exp_ev(EV_DOUBLE, t + 7);
        hold(1'b1, 2);
        hold(1'b0, 2);
        hold(1'b1, 2);
        hold(1'b0, 10);
        drain_check("t3_double");

        // 4a: second press sampled on the gap-expiry cycle still counts as double click
        t = cyc;
        exp_ev(EV_PRESS, t + 1);
        exp_ev(EV_RELEASE, t + 3);
        exp_ev(EV_PRESS, t + 7);
        exp_ev(EV_RELEASE, t + 9);
        exp_ev(EV_DOUBLE, t + 9);
        hold(1'b1, 2);
        hold(1'b0, 4);
        hold(1'b1, 2);
        hold(1'b0, 10);
        drain_check("t4a_rise_on_expiry");

        // 4b: press one cycle after expiry is a new gesture
        t = cyc;
        exp_ev(EV_PRESS, t + 1);
        exp_ev(EV_RELEASE, t + 3);
        exp_ev(EV_SHORT, t + 7);
        exp_ev(EV_PRESS, t + 8);
        exp_ev(EV_RELEASE, t + 10);
        exp_ev(EV_SHORT, t + 14);
        hold(1'b1, 2);
        hold(1'b0, 5);
        hold(1'b1, 2);
        hold(1'b0, 10);
        drain_check("t4b_after_expiry");

        // 5: release on the long-expiry cycle wins
        t = cyc;
        exp_ev(EV_PRESS, t + 1);
        exp_ev(EV_RELEASE, t + 9);
        exp_ev(EV_SHORT, t + 13);
        hold(1'b1, 8);
        hold(1'b0, 10);
        drain_check("t5_fall_on_expiry");

        // 5b: one cycle longer reaches long press, release is silent
        t = cyc;
        exp_ev(EV_PRESS, t + 1);
        exp_ev(EV_LONG, t + 9);
        exp_ev(EV_RELEASE, t + 10);
        hold(1'b1, 9);
        hold(1'b0, 10);
        drain_check("t5b_just_long");

        // 6a: reset while a repeat pulse is high in HOLD
        t = cyc;
        exp_ev(EV_PRESS, t + 1);
        exp_ev(EV_LONG, t + 9);
        exp_ev(EV_REPEAT, t + 12);
        hold(1'b1, 12);
        #2 rst_n = 1'b0;
        #1 check_quiet("t6a_reset_in_hold");
        btn_db = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        hold(1'b0, 12);
        drain_check("t6a_after_reset");

        // 6b: reset in WAIT2 aborts the pending short press; button held through reset
        t = cyc;
        exp_ev(EV_PRESS, t + 1);
        exp_ev(EV_RELEASE, t + 3);
        hold(1'b1, 2);
        hold(1'b0, 2);
        #2 rst_n = 1'b0;
        #1 check_quiet("t6b_reset_in_wait2");
        btn_db = 1'b1;
        repeat (2) @(negedge clk);
        drain_check("t6b_before_release");
        rst_n = 1'b1;
        t = cyc;
        exp_ev(EV_PRESS, t + 1);
        exp_ev(EV_RELEASE, t + 4);
        exp_ev(EV_SHORT, t + 8);
        hold(1'b1, 3);
        hold(1'b0, 10);
        drain_check("t6b_press_at_deassert");
        check_quiet("final_idle");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
